// File: rtl/mips_150.sv
// Serial echo subsystem: 8N1 UART receiver and transmitter with a sequencer that retransmits every well-framed byte.
// Define MIPS150_RX_FIFO_EN to replace the single-byte RX buffer with a 4-entry first-word-fall-through FIFO.
module mips_150 #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic clk,
  input  logic rst,
  input  logic stall,
  input  logic FPGA_SERIAL_RX,
  output logic FPGA_SERIAL_TX
);
  localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  // Handshake: buf_valid/buf_pop form a valid/ready pair; the sequencer pops only
  // while buf_valid is high, and tx_start is pulsed only while the transmitter is idle.
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [1:0] {SEQ_IDLE, SEQ_LOAD, SEQ_WAIT_TX, SEQ_SEND} seq_state_e;
  typedef enum logic {TX_IDLE, TX_BUSY} tx_state_e;

  logic rx_meta_q, rx_meta_d, rx_sync_q, rx_sync_d, rx_prev_q, rx_prev_d;
  rx_state_e rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic rx_push;

  logic buf_valid, buf_pop;
  logic [7:0] buf_data;

  seq_state_e seq_state_q, seq_state_d;
  logic [7:0] echo_q, echo_d;
  logic tx_start;

  tx_state_e tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0] tx_bit_q, tx_bit_d;
  logic [8:0] tx_shift_q, tx_shift_d;
  logic tx_out_q, tx_out_d;
  logic tx_idle;

  always_comb begin
    rx_meta_d = FPGA_SERIAL_RX;
    rx_sync_d = rx_meta_q;
    rx_prev_d = rx_sync_q;
  end

  // Receiver: the shifter fills from the top so the first (LSB) bit ends in bit 0.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_push    = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
          rx_push    = rx_sync_q;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

`ifdef MIPS150_RX_FIFO_EN
  logic [7:0] fifo_mem_q [4];
  logic [7:0] fifo_mem_d [4];
  logic [1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0] count_q, count_d;
  logic push_ok, pop_ok;

  // A full FIFO still takes a byte when the same cycle frees an entry.
  always_comb begin
    fifo_mem_d = fifo_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    pop_ok     = buf_pop && (count_q != 3'd0);
    push_ok    = rx_push && ((count_q != 3'd4) || pop_ok);
    if (push_ok) begin
      fifo_mem_d[wr_ptr_q] = rx_shift_q;
      wr_ptr_d = wr_ptr_q + 2'd1;
    end
    if (pop_ok) rd_ptr_d = rd_ptr_q + 2'd1;
    if (push_ok && !pop_ok) count_d = count_q + 3'd1;
    else if (!push_ok && pop_ok) count_d = count_q - 3'd1;
  end

  assign buf_valid = (count_q != 3'd0);
  assign buf_data  = fifo_mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) fifo_mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      fifo_mem_q <= fifo_mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end
`else
  logic buf_valid_q, buf_valid_d;
  logic [7:0] buf_data_q, buf_data_d;

  // A full buffer keeps its byte unless the same cycle pops it.
  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_data_d  = buf_data_q;
    if (buf_pop) buf_valid_d = 1'b0;
    if (rx_push && (!buf_valid_q || buf_pop)) begin
      buf_valid_d = 1'b1;
      buf_data_d  = rx_shift_q;
    end
  end

  assign buf_valid = buf_valid_q;
  assign buf_data  = buf_data_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      buf_valid_q <= 1'b0;
      buf_data_q  <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_data_q  <= buf_data_d;
    end
  end
`endif

  always_comb begin
    seq_state_d = seq_state_q;
    echo_d      = echo_q;
    buf_pop     = 1'b0;
    tx_start    = 1'b0;
    if (!stall) begin
      unique case (seq_state_q)
        SEQ_IDLE:    if (buf_valid) seq_state_d = SEQ_LOAD;
        SEQ_LOAD: begin
          echo_d      = buf_data;
          buf_pop     = 1'b1;
          seq_state_d = SEQ_WAIT_TX;
        end
        SEQ_WAIT_TX: if (tx_idle) seq_state_d = SEQ_SEND;
        SEQ_SEND: begin
          tx_start    = tx_idle;
          seq_state_d = SEQ_IDLE;
        end
        default: seq_state_d = SEQ_IDLE;
      endcase
    end
  end

  assign tx_idle = (tx_state_q == TX_IDLE);

  // Transmitter: the start bit goes straight to the output; the shifter holds data then stop.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_out_d   = tx_out_q;
    unique case (tx_state_q)
      TX_IDLE: begin
        tx_out_d = 1'b1;
        if (tx_start) begin
          tx_out_d   = 1'b0;
          tx_shift_d = {1'b1, echo_q};
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = TX_BUSY;
        end
      end
      TX_BUSY: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 4'd9) begin
            tx_out_d   = 1'b1;
            tx_state_d = TX_IDLE;
          end else begin
            tx_out_d   = tx_shift_q[0];
            tx_shift_d = {1'b1, tx_shift_q[8:1]};
            tx_bit_d   = tx_bit_q + 4'd1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  assign FPGA_SERIAL_TX = tx_out_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_prev_q   <= 1'b1;
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      seq_state_q <= SEQ_IDLE;
      echo_q      <= '0;
      tx_state_q  <= TX_IDLE;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_shift_q  <= '1;
      tx_out_q    <= 1'b1;
    end else begin
      rx_meta_q   <= rx_meta_d;
      rx_sync_q   <= rx_sync_d;
      rx_prev_q   <= rx_prev_d;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      seq_state_q <= seq_state_d;
      echo_q      <= echo_d;
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
      tx_out_q    <= tx_out_d;
    end
  end
endmodule

// File: tb/tb_mips_150.sv
// Bench for mips_150: host UART driver, TX-line monitor with an expected-byte queue, and a final report.
module tb_mips_150;
  localparam int CLOCK_FREQ = 1_000_000;
  localparam int BAUD_RATE  = 62_500;
  localparam int CPB = CLOCK_FREQ / BAUD_RATE;

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    logic       exp_echo;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic stall = 1'b0;
  logic rx = 1'b1;
  logic tx;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic mon_en = 1'b1;
  logic mon_busy = 1'b0;

  always #5 clk = ~clk;

  mips_150 #(.CLOCK_FREQ(CLOCK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .FPGA_SERIAL_RX(rx),
    .FPGA_SERIAL_TX(tx)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Host-side UART: one 8N1 frame; lat reports the first stop-bit cycle where TX is low.
  task automatic send_byte(input logic [7:0] d, input logic stop_bit, output int lat);
    lat = -1;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    for (int c = 1; c <= CPB; c++) begin
      @(negedge clk);
      if (tx === 1'b0 && lat < 0) lat = c;
    end
    rx = 1'b1;
  endtask

  task automatic host_send(input logic [7:0] d, input logic stop_bit, output int lat);
    if (stop_bit) exp_q.push_back(d);
    send_byte(d, stop_bit, lat);
    if (!stop_bit) repeat (CPB) @(negedge clk);
  endtask

  task automatic mon_wait(input int n, inout bit ab);
    repeat (n) begin
      @(negedge clk);
      if (!mon_en) ab = 1'b1;
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || mon_busy) && n < 40 * CPB) begin
      @(negedge clk);
      n++;
    end
    check(name, exp_q.size(), 0);
    exp_q.delete();
    repeat (3 * CPB) @(negedge clk);
  endtask

  task automatic count_tx_low(input int n, output int lows);
    lows = 0;
    repeat (n) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
  endtask

  initial begin : monitor
    logic [7:0] b;
    logic [7:0] e;
    logic s0, s9;
    bit aborted;
    forever begin
      @(negedge clk);
      if (mon_en && tx === 1'b0) begin
        mon_busy = 1'b1;
        aborted = 1'b0;
        mon_wait(CPB / 2, aborted);
        s0 = tx;
        for (int i = 0; i < 8; i++) begin
          mon_wait(CPB, aborted);
          b[i] = tx;
        end
        mon_wait(CPB, aborted);
        s9 = tx;
        if (!aborted) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_echo: got 0x%02h, expected no frame", b);
          end else begin
            e = exp_q.pop_front();
            check("echo_data", b, e);
            check("echo_start_bit", s0, 0);
            check("echo_stop_bit", s9, 1);
          end
        end
        mon_busy = 1'b0;
      end
    end
  end

  initial begin : watchdog
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    vec_t tab[6];
    int lat;
    int lows;
    int n;
    logic [7:0] d;
    logic sb;

    tab[0] = '{8'h00, 1'b1, 1'b1};
    tab[1] = '{8'hFF, 1'b1, 1'b1};
    tab[2] = '{8'hA5, 1'b0, 1'b0};
    tab[3] = '{8'h3C, 1'b1, 1'b1};
    tab[4] = '{8'h01, 1'b1, 1'b1};
    tab[5] = '{8'h80, 1'b1, 1'b1};

    repeat (30) @(negedge clk);
    check("tx_in_reset", tx, 1);
    rst = 1'b1;
    count_tx_low(2 * CPB, lows);
    check("tx_idle_after_reset", lows, 0);

    host_send(8'h7A, 1'b1, lat);
    checks++;
    if (lat < CPB / 2 || lat > CPB / 2 + 8) begin
      errors++;
      $display("FAIL echo_latency: got %0d cycles, expected %0d..%0d", lat, CPB / 2, CPB / 2 + 8);
    end
    wait_drain("drain_7a");
    check("tx_high_after_7a", tx, 1);

    rst = 1'b0;
    repeat (30) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    host_send(8'h88, 1'b1, lat);
    wait_drain("drain_88");

    for (int i = 0; i < 6; i++) begin
      if (tab[i].exp_echo) exp_q.push_back(tab[i].data);
      send_byte(tab[i].data, tab[i].stop_bit, lat);
      if (!tab[i].stop_bit) repeat (CPB) @(negedge clk);
    end
    wait_drain("drain_table");

    stall = 1'b1;
    exp_q.push_back(8'h55);
    send_byte(8'h55, 1'b1, lat);
    check("stall_no_echo_in_stop", lat, -1);
    count_tx_low(4 * CPB, lows);
    check("stall_tx_high", lows, 0);
    stall = 1'b0;
    wait_drain("drain_stall_release");

    for (int i = 0; i < 12; i++) begin
      d = 8'($urandom_range(0, 255));
      sb = ($urandom_range(0, 4) != 0);
      host_send(d, sb, lat);
    end
    wait_drain("drain_random");

    mon_en = 1'b0;
    send_byte(8'hC3, 1'b1, lat);
    n = 0;
    while (tx !== 1'b0 && n < 20 * CPB) begin
      @(negedge clk);
      n++;
    end
    check("reset_test_tx_started", tx, 0);
    repeat (3 * CPB) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("tx_high_after_mid_reset", tx, 1);
    count_tx_low(30, lows);
    check("tx_high_during_reset", lows, 0);
    rst = 1'b1;
    count_tx_low(12 * CPB, lows);
    check("tx_high_after_abort", lows, 0);
    mon_en = 1'b1;
    host_send(8'h96, 1'b1, lat);
    wait_drain("drain_after_abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
